// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types, frame defaults and neighbour slice indices for the Sobel engine.
package sobel_pkg;
   localparam int H_PIXELS_DEF = 640;
   localparam int V_LINES_DEF  = 480;
   localparam int THRESH_DEF   = 64;

   typedef logic [7:0]         pixel_t;
   typedef logic signed [10:0] grad_t;
   typedef pixel_t [7:0]       nbr_t;

   // Element 7 is the MSB byte of inputPixels, so NW lands at the top.
   localparam int IDX_NW = 7;
   localparam int IDX_N  = 6;
   localparam int IDX_NE = 5;
   localparam int IDX_W  = 4;
   localparam int IDX_E  = 3;
   localparam int IDX_SW = 2;
   localparam int IDX_S  = 1;
   localparam int IDX_SE = 0;

   function automatic nbr_t unpack_pixels(input logic [63:0] p);
      return nbr_t'(p);
   endfunction

   function automatic grad_t ext(input pixel_t p);
      return grad_t'({3'b000, p});
   endfunction
endpackage

// File: rtl/sobel_kernel.sv
// sobel_kernel: combinational 3x3 Sobel gradients Gx/Gy from the 8 neighbours of a pixel.
module sobel_kernel
   import sobel_pkg::*;
(
   input  nbr_t  pix_i,
   output grad_t gx_o,
   output grad_t gy_o
);
   assign gx_o = ext(pix_i[IDX_NE]) + ext(pix_i[IDX_E]) + ext(pix_i[IDX_E]) + ext(pix_i[IDX_SE])
               - ext(pix_i[IDX_NW]) - ext(pix_i[IDX_W]) - ext(pix_i[IDX_W]) - ext(pix_i[IDX_SW]);
   assign gy_o = ext(pix_i[IDX_SW]) + ext(pix_i[IDX_S]) + ext(pix_i[IDX_S]) + ext(pix_i[IDX_SE])
               - ext(pix_i[IDX_NW]) - ext(pix_i[IDX_N]) - ext(pix_i[IDX_N]) - ext(pix_i[IDX_NE]);
endmodule

// File: rtl/sobel.sv
// sobel: 3-stage pipelined Sobel |Gx|+|Gy| edge magnitude, saturated to 8 bits, borders forced to 0.
// Define SOBEL_THRESHOLD_EN to binarise the magnitude against THRESH instead of saturating.
module sobel
   import sobel_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_LINES  = V_LINES_DEF
`ifdef SOBEL_THRESHOLD_EN
   ,
   parameter int THRESH   = THRESH_DEF
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  row,
   input  logic [9:0]  col,
   input  logic [63:0] inputPixels,
   input  logic        start,
   output logic [7:0]  out,
   output logic        done
);
   nbr_t        pix_q;
   logic        v1_q, b1_q, v2_q, b2_q, done_q;
   grad_t       gx_d, gy_d, gx_q, gy_q;
   logic [10:0] ax, ay, mag;
   pixel_t      res, out_d, out_q;
   logic        border;

   assign border = (row == 10'd0) | (row == 10'(V_LINES - 1)) |
                   (col == 10'd0) | (col == 10'(H_PIXELS - 1));

   sobel_kernel u_kernel (.pix_i(pix_q), .gx_o(gx_d), .gy_o(gy_d));

   always_comb begin
      ax  = gx_q[10] ? -gx_q : gx_q;
      ay  = gy_q[10] ? -gy_q : gy_q;
      mag = ax + ay;
`ifdef SOBEL_THRESHOLD_EN
      res = (mag >= 11'(THRESH)) ? 8'hFF : 8'h00;
`else
      res = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
      // Output holds its last value between results.
      out_d = !v2_q ? out_q : b2_q ? 8'h00 : res;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pix_q  <= '0;
         v1_q   <= 1'b0;
         b1_q   <= 1'b0;
         gx_q   <= '0;
         gy_q   <= '0;
         v2_q   <= 1'b0;
         b2_q   <= 1'b0;
         done_q <= 1'b0;
         out_q  <= '0;
      end else begin
         v1_q <= start;
         if (start) begin
            pix_q <= unpack_pixels(inputPixels);
            b1_q  <= border;
         end
         gx_q   <= gx_d;
         gy_q   <= gy_d;
         v2_q   <= v1_q;
         b2_q   <= b1_q;
         done_q <= v2_q;
         out_q  <= out_d;
      end

   assign out  = out_q;
   assign done = done_q;
endmodule

// File: tb/tb_sobel.sv
// tb_sobel: randomized scoreboard bench for sobel; expected results queued at issue, checked by a monitor.
module tb_sobel;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [9:0]  row = '0, col = '0;
   logic [63:0] inputPixels = '0;
   logic [7:0]  out;
   logic        done;

   typedef struct { logic [7:0] v; int cyc; } exp_t;
   exp_t       q[$];
   int         cyc = 0, vectors = 0, miscompares = 0;
   logic [7:0] last = 8'h00;

   sobel dut (.clk(clk), .reset(reset), .row(row), .col(col), .inputPixels(inputPixels),
              .start(start), .out(out), .done(done));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [7:0] ref_out(input logic [63:0] p, input int r, input int c);
      int v[8];
      int gx, gy, mag;
      for (int i = 0; i < 8; i++) v[i] = int'(p[63-8*i -: 8]);
      gx  = (v[2] + 2*v[4] + v[7]) - (v[0] + 2*v[3] + v[5]);
      gy  = (v[5] + 2*v[6] + v[7]) - (v[0] + 2*v[1] + v[2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (r == 0 || r == 479 || c == 0 || c == 639) return 8'd0;
`ifdef SOBEL_THRESHOLD_EN
      return (mag >= 64) ? 8'd255 : 8'd0;
`else
      return (mag > 255) ? 8'd255 : 8'(mag);
`endif
   endfunction

   function automatic logic [63:0] pk(input int nw, n, ne, w, e, sw, s, se);
      return {8'(nw), 8'(n), 8'(ne), 8'(w), 8'(e), 8'(sw), 8'(s), 8'(se)};
   endfunction

   // Called at a negedge; the pixel is sampled on the next posedge and its result is seen 3 negedges later.
   task automatic issue(input logic [63:0] p, input int r, input int c, input logic [7:0] e);
      row = 10'(r);
      col = 10'(c);
      inputPixels = p;
      start = 1'b1;
      q.push_back('{e, cyc + 3});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic rand_issue();
      logic [63:0] p;
      int r, c;
      p = {$urandom, $urandom};
      r = $urandom_range(0, 479);
      c = $urandom_range(0, 639);
      issue(p, r, c, ref_out(p, r, c));
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         if (done) begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: out=%0d with no result pending (t=%0t)", out, $time);
            end else begin
               e = q.pop_front();
               check("result", out, e.v);
               vectors++;
               if (cyc != e.cyc) begin
                  miscompares++;
                  $display("FAIL latency: result at cycle %0d, expected cycle %0d", cyc, e.cyc);
               end
               last = e.v;
            end
         end else check("hold", out, last);
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_out", out, 8'd0);
      check("reset_done", {7'd0, done}, 8'd0);
      reset = 1'b1;
      @(negedge clk);
      issue(pk(100, 100, 100, 100, 100, 100, 100, 100), 5, 5, 8'd0);
      repeat (4) @(negedge clk);
`ifdef SOBEL_THRESHOLD_EN
      issue(pk(0, 0, 10, 0, 10, 0, 0, 10), 10, 10, 8'd0);
      issue(pk(0, 0, 0, 0, 0, 20, 20, 20), 10, 10, 8'd255);
      issue(pk(3, 0, 0, 0, 0, 0, 0, 0), 10, 10, 8'd0);
`else
      issue(pk(0, 0, 10, 0, 10, 0, 0, 10), 10, 10, 8'd40);
      issue(pk(0, 0, 0, 0, 0, 20, 20, 20), 10, 10, 8'd80);
      issue(pk(3, 0, 0, 0, 0, 0, 0, 0), 10, 10, 8'd6);
`endif
      issue(pk(0, 0, 255, 0, 255, 0, 0, 255), 10, 10, 8'd255);
      issue(pk(0, 0, 255, 0, 255, 0, 0, 255), 0, 5, 8'd0);
      issue(pk(0, 0, 255, 0, 255, 0, 0, 255), 5, 639, 8'd0);
      issue(pk(0, 0, 255, 0, 255, 0, 0, 255), 479, 5, 8'd0);
      issue(pk(0, 0, 255, 0, 255, 0, 0, 255), 5, 0, 8'd0);
      issue(pk(0, 0, 255, 0, 255, 0, 0, 255), 700, 1000, 8'd255);
      issue(pk(255, 0, 0, 0, 0, 0, 0, 0), 1, 1, 8'd255);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 100; i++) rand_issue();
      repeat (5) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) @(negedge clk);
         rand_issue();
      end
      for (int i = 0; i < 10; i++) rand_issue();
      start = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("midreset_done", {7'd0, done}, 8'd0);
      check("midreset_out", out, 8'd0);
      q.delete();
      last  = 8'h00;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      issue(pk(0, 0, 255, 0, 255, 0, 0, 255), 20, 20, 8'd255);
      for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d results still pending, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
